// File: rtl/s1_window_accumulator.sv
// Window statistics stage behind the S1 logic-cell chain: accumulates len valid
// samples and reports their sum, maximum and minimum, then pulses done for one cycle.
module s1_window_accumulator #(
  parameter int size  = 5,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    CLR,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [size-1:0]         in_data,
  input  logic                    in_valid,
  output logic [size+LEN_W-1:0]   sum_out,
  output logic [size-1:0]         max_out,
  output logic [size-1:0]         min_out,
  output logic                    busy,
  output logic                    done
);

  localparam int SUM_W = size + LEN_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic [SUM_W-1:0]   sum_n;
  logic [size-1:0]    max_n, min_n;
  logic [LEN_W-1:0]   cnt_inc;

  // Sum width already covers (2^LEN_W-1) * (2^size-1), so plain zero-extended add never wraps.
  function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] acc,
                                               input logic [size-1:0]  x);
    sum_add = acc + {{LEN_W{1'b0}}, x};
  endfunction

  function automatic logic [size-1:0] umax(input logic [size-1:0] a,
                                           input logic [size-1:0] b);
    umax = (b > a) ? b : a;
  endfunction

  function automatic logic [size-1:0] umin(input logic [size-1:0] a,
                                           input logic [size-1:0] b);
    umin = (b < a) ? b : a;
  endfunction

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n = state;
    len_n   = len_q;
    cnt_n   = cnt;
    sum_n   = sum_out;
    max_n   = max_out;
    min_n   = min_out;
    unique case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          len_n   = len;
          cnt_n   = '0;
          sum_n   = '0;
          max_n   = '0;
          min_n   = {size{1'b1}};
          state_n = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          sum_n = sum_add(sum_out, in_data);
          max_n = umax(max_out, in_data);
          min_n = umin(min_out, in_data);
          cnt_n = cnt_inc;
          if (cnt_inc == len_q) state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with the data registers.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      sum_out <= '0;
      max_out <= '0;
      min_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      len_q   <= len_n;
      cnt     <= cnt_n;
      sum_out <= sum_n;
      max_out <= max_n;
      min_out <= min_n;
      busy    <= (state_n == ACC);
      done    <= (state_n == DONE);
    end
  end

endmodule

// File: doc/s1_window_accumulator.md
Name: s1_window_accumulator

Overview:
Downstream consumer of the S1 registered logic-cell stage. It takes S1's `size`-bit output word stream and accumulates a window of `len` valid samples. Per window it reports the sum, maximum and minimum of the samples, then raises a one-cycle completion flag. It is the statistics/collection stage that the cell chain feeds in the CA3 datapath.

Parameters:
- size, 5, width of each incoming data word; must match the S1 stage's size.
- LEN_W, 4, width of the window-length input; maximum window is 2^LEN_W-1 samples.
- (derived, local) SUM_W = size+LEN_W, width of the sum; the sum cannot overflow by construction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  begin a new window; sampled only in IDLE.
- len  input  LEN_W  window length; sampled together with an accepted start.
- in_data  input  size  sample word from the S1 stage output.
- in_valid  input  1  in_data holds a sample to accumulate this cycle.
- sum_out  output  SUM_W  running and then final sum of the window's samples.
- max_out  output  size  running and then final maximum sample.
- min_out  output  size  running and then final minimum sample.
- busy  output  1  high while a window is being collected (ACC state).
- done  output  1  one-cycle pulse once the window completes.

Behaviour:
- Reset (CLR=1, asynchronous, any state):
  - FSM goes to IDLE; internal sample counter cleared.
  - sum_out=0, max_out=0, min_out=0, busy=0, done=0.
  - All outputs stay at these values while CLR is held.
- FSM states are IDLE, ACC and DONE; all outputs are registered.
- IDLE:
  - start=1 with len!=0: capture len. Next edge: sum_out=0, max_out=0, min_out={size{1'b1}}, counter=0, state=ACC, busy=1.
  - start=1 with len==0: ignored; stay IDLE and outputs unchanged (previous results are kept).
  - in_valid in IDLE is ignored. A sample presented in the same cycle as the accepted start is not counted.
- ACC:
  - Each edge with in_valid=1:
    - sum_out += in_data (zero-extended);
    - max_out = max(max_out, in_data);
    - min_out = min(min_out, in_data);
    - counter += 1.
  - in_valid=0 cycles change nothing, so gaps are allowed without limit.
  - When the accepted sample is the len-th one: on that same edge the final sample is folded in, state goes to DONE and busy drops to 0.
  - start asserted during ACC is ignored; len changes during ACC are ignored because the captured copy is used.
- DONE:
  - Lasts exactly one cycle, with done=1.
  - Outputs hold the final results. Next edge: state=IDLE, done=0.
  - start asserted during DONE is ignored.
- Output holding:
  - Results persist in IDLE until the next accepted start or CLR.
  - Latency: done is high in the cycle after the edge that accepts the final sample.
- Arithmetic:
  - All comparisons are unsigned.
  - Worst case sum is (2^LEN_W-1)*(2^size-1), which is less than 2^SUM_W, so there is no saturation or wrap.
- Window of one (len=1): the first valid sample completes the window; max_out=min_out=sum_out=that sample.
- CLR mid-window: the window is abandoned with no done pulse and all outputs are cleared. A fresh start is required afterwards.

Test Plan:
1. Reset values: assert CLR asynchronously between clock edges → all outputs 0 immediately; busy=0, done=0.
2. Basic window: start with len=4, then samples 3, 7, 1, 31 with in_valid on back-to-back cycles → sum_out=42, max_out=31, min_out=1; done pulses one cycle after the 31 is accepted; busy=0 from then on.
3. Gapped valid: len=3, samples 10, (2 idle cycles), 20, (1 idle cycle), 5 → sum_out=35, max_out=20, min_out=5. Also check that a start pulsed mid-window is ignored (busy stays 1 and the window is not restarted).
4. Boundaries:
   - len=0 start → no busy, no done, and the previous results are unchanged.
   - len=1 with sample 0 → sum_out=max_out=min_out=0 and done pulses.
5. Maximum window: size=5, LEN_W=4, len=15, all samples 31 → sum_out=465 (9 bits, no overflow), max_out=min_out=31.
6. Reset mid-window: len=8, 3 samples accepted, then CLR pulse → outputs 0, no done. A new start with len=2 and samples 4, 6 → sum_out=10, max_out=6, min_out=4, done pulses.
